// File: rtl/divu_seq.sv
// divu_seq: multi-cycle radix-2 restoring unsigned divider that owns the
// HI/LO register pair. It serves mfhi/mflo reads and stalls the pipeline
// front for dependent instructions while a divide is in flight.
module divu_seq #(
  parameter int WIDTH = 32,
  parameter int CW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       alusel,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hilo_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  // The partial remainder is architecturally WIDTH+1 bits wide. After every
  // restore/subtract step its top bit is zero, so only the low WIDTH bits
  // are kept. The trial subtraction below is still done WIDTH+1 bits wide.
  logic [WIDTH-1:0] rem_r, rem_s;
  logic [WIDTH-1:0] q_r, q_s;
  logic [WIDTH-1:0] dvs_r, dvs_s;
  logic [WIDTH-1:0] hi_r, hi_s;
  logic [WIDTH-1:0] lo_r, lo_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] rem_step_s;
  logic [WIDTH-1:0] q_step_s;
  logic             last_s;

  // One restoring-division iteration: shift in the next dividend bit and
  // try to subtract the divisor.
  always_comb begin
    trial_s    = {rem_r, q_r[WIDTH-1]} - {1'b0, dvs_r};
    shifted_s  = {rem_r[WIDTH-2:0], q_r[WIDTH-1]};
    if (trial_s[WIDTH] == 1'b0) begin
      rem_step_s = trial_s[WIDTH-1:0];
    end else begin
      rem_step_s = shifted_s;
    end
    q_step_s   = {q_r[WIDTH-2:0], ~trial_s[WIDTH]};
    last_s     = (cnt_r == CW'(WIDTH - 1));
  end

  // Next-state and datapath update logic for the sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    rem_s   = rem_r;
    q_s     = q_r;
    dvs_s   = dvs_r;
    hi_s    = hi_r;
    lo_s    = lo_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (divisor != {WIDTH{1'b0}}) begin
            dvs_s   = divisor;
            q_s     = dividend;
            rem_s   = {WIDTH{1'b0}};
            cnt_s   = {CW{1'b0}};
            state_s = ST_RUN;
          end else begin
            // Divide by zero commits immediately without iterating.
            lo_s    = {WIDTH{1'b1}};
            hi_s    = dividend;
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        rem_s = rem_step_s;
        q_s   = q_step_s;
        cnt_s = cnt_r + CW'(1);
        if (last_s) begin
          lo_s    = q_step_s;
          hi_s    = rem_step_s;
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s == ST_RUN);
    done_s = (state_s == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      rem_r   <= {WIDTH{1'b0}};
      q_r     <= {WIDTH{1'b0}};
      dvs_r   <= {WIDTH{1'b0}};
      hi_r    <= {WIDTH{1'b0}};
      lo_r    <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      rem_r   <= rem_s;
      q_r     <= q_s;
      dvs_r   <= dvs_s;
      hi_r    <= hi_s;
      lo_r    <= lo_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Combinational stall and HI/LO read port.
  always_comb begin
    stall = busy_r & (start | (alusel == 2'd0) | (alusel == 2'd1));
    case (alusel)
      2'd0:    hilo_out = hi_r;
      2'd1:    hilo_out = lo_r;
      default: hilo_out = {WIDTH{1'b0}};
    endcase
  end

  assign busy = busy_r;
  assign done = done_r;
  assign hi   = hi_r;
  assign lo   = lo_r;

endmodule
